// File: rtl/wb_intercon_1x4_pkg.sv
// Shared constants for the 1-master / 4-slave Wishbone interconnect.
// Bus widths and the mask/base pair that leaves a slave port disabled.
package wb_intercon_1x4_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int N_SLV    = 4;

    // Mask 0 makes every address compare as 0, which never equals all-ones.
    localparam logic [WB_ADR_W-1:0] SLV_OFF_MASK = 32'h0000_0000;
    localparam logic [WB_ADR_W-1:0] SLV_OFF_ADDR = 32'hFFFF_FFFF;

endpackage

// File: rtl/wb_addr_decode.sv
// Address decoder: per-slave mask/base hit test plus fixed priority 0>1>2>3.
// Ports: adr (master address) in; sel (one-hot or zero slave select) out.
module wb_addr_decode
    import wb_intercon_1x4_pkg::*;
#(
    parameter logic [N_SLV-1:0][WB_ADR_W-1:0] MASKS = '0,
    parameter logic [N_SLV-1:0][WB_ADR_W-1:0] ADDRS = '1
) (
    input  logic [WB_ADR_W-1:0] adr,
    output logic [N_SLV-1:0]    sel
);

    logic [N_SLV-1:0] hit;
    logic             lower;

    always_comb begin
        hit   = '0;
        sel   = '0;
        lower = 1'b0;
        for (int i = 0; i < N_SLV; i++) begin
            hit[i] = ((adr & MASKS[i]) == ADDRS[i]);
            // A lower-numbered hit masks every higher one.
            sel[i] = hit[i] & ~lower;
            lower  = lower | hit[i];
        end
    end

endmodule

// File: rtl/wb_intercon_1x4.sv
// Wishbone B3 classic shared bus: one master to four slaves, with bus error
// on unmapped access or slave timeout. Ports: clk_i/rst_i, wbm_* master side,
// wbs_N_* slave side (N=0..3); adr/dat/sel/we broadcast, cyc/stb gated.
module wb_intercon_1x4
    import wb_intercon_1x4_pkg::*;
#(
    parameter logic [WB_ADR_W-1:0] slave_0_mask = 32'hFFFF_F000,
    parameter logic [WB_ADR_W-1:0] slave_0_addr = 32'h0000_1000,
    parameter logic [WB_ADR_W-1:0] slave_1_mask = SLV_OFF_MASK,
    parameter logic [WB_ADR_W-1:0] slave_1_addr = SLV_OFF_ADDR,
    parameter logic [WB_ADR_W-1:0] slave_2_mask = SLV_OFF_MASK,
    parameter logic [WB_ADR_W-1:0] slave_2_addr = SLV_OFF_ADDR,
    parameter logic [WB_ADR_W-1:0] slave_3_mask = SLV_OFF_MASK,
    parameter logic [WB_ADR_W-1:0] slave_3_addr = SLV_OFF_ADDR,
    parameter int                  SEL_W        = 2,
    parameter int                  TIMEOUT      = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [WB_ADR_W-1:0] wbm_adr_i,
    input  logic [WB_DAT_W-1:0] wbm_dat_i,
    output logic [WB_DAT_W-1:0] wbm_dat_o,
    input  logic [SEL_W-1:0]    wbm_sel_i,
    input  logic                wbm_we_i,
    input  logic                wbm_cyc_i,
    input  logic                wbm_stb_i,
    output logic                wbm_ack_o,
    output logic                wbm_err_o,
    output logic [WB_ADR_W-1:0] wbs_0_adr_o,
    output logic [WB_DAT_W-1:0] wbs_0_dat_o,
    input  logic [WB_DAT_W-1:0] wbs_0_dat_i,
    output logic [SEL_W-1:0]    wbs_0_sel_o,
    output logic                wbs_0_we_o,
    output logic                wbs_0_cyc_o,
    output logic                wbs_0_stb_o,
    input  logic                wbs_0_ack_i,
    output logic [WB_ADR_W-1:0] wbs_1_adr_o,
    output logic [WB_DAT_W-1:0] wbs_1_dat_o,
    input  logic [WB_DAT_W-1:0] wbs_1_dat_i,
    output logic [SEL_W-1:0]    wbs_1_sel_o,
    output logic                wbs_1_we_o,
    output logic                wbs_1_cyc_o,
    output logic                wbs_1_stb_o,
    input  logic                wbs_1_ack_i,
    output logic [WB_ADR_W-1:0] wbs_2_adr_o,
    output logic [WB_DAT_W-1:0] wbs_2_dat_o,
    input  logic [WB_DAT_W-1:0] wbs_2_dat_i,
    output logic [SEL_W-1:0]    wbs_2_sel_o,
    output logic                wbs_2_we_o,
    output logic                wbs_2_cyc_o,
    output logic                wbs_2_stb_o,
    input  logic                wbs_2_ack_i,
    output logic [WB_ADR_W-1:0] wbs_3_adr_o,
    output logic [WB_DAT_W-1:0] wbs_3_dat_o,
    input  logic [WB_DAT_W-1:0] wbs_3_dat_i,
    output logic [SEL_W-1:0]    wbs_3_sel_o,
    output logic                wbs_3_we_o,
    output logic                wbs_3_cyc_o,
    output logic                wbs_3_stb_o,
    input  logic                wbs_3_ack_i
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [N_SLV-1:0] sel;
    logic [N_SLV-1:0] req_sel;
    logic [N_SLV-1:0] tgt_q;
    logic [7:0]       cnt;
    logic             err_q;
    logic             req;
    logic             slv_ack;
    logic             waiting;
    logic             unmapped;

    wb_addr_decode #(
        .MASKS({slave_3_mask, slave_2_mask, slave_1_mask, slave_0_mask}),
        .ADDRS({slave_3_addr, slave_2_addr, slave_1_addr, slave_0_addr})
    ) u_dec (
        .adr(wbm_adr_i),
        .sel(sel)
    );

    assign req     = wbm_cyc_i & wbm_stb_i;
    assign req_sel = sel & {N_SLV{req}};

    assign wbs_0_adr_o = wbm_adr_i;
    assign wbs_1_adr_o = wbm_adr_i;
    assign wbs_2_adr_o = wbm_adr_i;
    assign wbs_3_adr_o = wbm_adr_i;
    assign wbs_0_dat_o = wbm_dat_i;
    assign wbs_1_dat_o = wbm_dat_i;
    assign wbs_2_dat_o = wbm_dat_i;
    assign wbs_3_dat_o = wbm_dat_i;
    assign wbs_0_sel_o = wbm_sel_i;
    assign wbs_1_sel_o = wbm_sel_i;
    assign wbs_2_sel_o = wbm_sel_i;
    assign wbs_3_sel_o = wbm_sel_i;
    assign wbs_0_we_o  = wbm_we_i;
    assign wbs_1_we_o  = wbm_we_i;
    assign wbs_2_we_o  = wbm_we_i;
    assign wbs_3_we_o  = wbm_we_i;

    assign wbs_0_cyc_o = wbm_cyc_i & sel[0];
    assign wbs_1_cyc_o = wbm_cyc_i & sel[1];
    assign wbs_2_cyc_o = wbm_cyc_i & sel[2];
    assign wbs_3_cyc_o = wbm_cyc_i & sel[3];
    assign wbs_0_stb_o = req_sel[0];
    assign wbs_1_stb_o = req_sel[1];
    assign wbs_2_stb_o = req_sel[2];
    assign wbs_3_stb_o = req_sel[3];

    // sel is one-hot or zero, so the cases below never overlap.
    always_comb begin
        wbm_dat_o = '0;
        slv_ack   = 1'b0;
        if (wbm_cyc_i) begin
            unique case (1'b1)
                sel[0]: begin
                    wbm_dat_o = wbs_0_dat_i;
                    slv_ack   = wbs_0_ack_i;
                end
                sel[1]: begin
                    wbm_dat_o = wbs_1_dat_i;
                    slv_ack   = wbs_1_ack_i;
                end
                sel[2]: begin
                    wbm_dat_o = wbs_2_dat_i;
                    slv_ack   = wbs_2_ack_i;
                end
                sel[3]: begin
                    wbm_dat_o = wbs_3_dat_i;
                    slv_ack   = wbs_3_ack_i;
                end
                default: begin
                    wbm_dat_o = '0;
                    slv_ack   = 1'b0;
                end
            endcase
        end
    end

    assign wbm_ack_o = req & slv_ack;
    assign waiting   = (|req_sel) & ~slv_ack;
    assign unmapped  = req & ~(|sel);
    assign wbm_err_o = err_q & ~wbm_ack_o;

    // A change of target counts as the first waiting cycle of a new access.
    // The unmapped error re-arms every other cycle so a held strobe
    // still sees single-cycle pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt   <= '0;
            err_q <= 1'b0;
            tgt_q <= '0;
        end else begin
            tgt_q <= req_sel;
            err_q <= unmapped & ~err_q;
            if (!waiting) begin
                cnt <= '0;
            end else if (req_sel != tgt_q) begin
                cnt <= 8'd1;
            end else if (cnt == TO_LAST) begin
                cnt   <= '0;
                err_q <= 1'b1;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_intercon_1x4.sv
// Self-checking bench for wb_intercon_1x4: table of combinational vectors
// plus hand-written sequences for error, timeout, reset and re-decode.
module tb_wb_intercon_1x4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] m_adr = '0;
    logic [31:0] m_wdat = '0;
    logic [31:0] m_rdat;
    logic [1:0]  m_sel = '0;
    logic        m_we = 1'b0;
    logic        m_cyc = 1'b0;
    logic        m_stb = 1'b0;
    logic        m_ack;
    logic        m_err;
    logic [31:0] s_adr [4];
    logic [31:0] s_wdat [4];
    logic [31:0] s_rdat [4];
    logic [1:0]  s_sel [4];
    logic [3:0]  s_we;
    logic [3:0]  s_cyc;
    logic [3:0]  s_stb;
    logic [3:0]  s_ack = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign s_rdat[0] = 32'hDEADBEEF;
    assign s_rdat[1] = 32'h1111_1111;
    assign s_rdat[2] = 32'h2222_2222;
    assign s_rdat[3] = 32'h3333_3333;

    wb_intercon_1x4 #(
        .slave_1_mask(32'hFFFF_0000),
        .slave_1_addr(32'h0001_0000),
        .slave_2_mask(32'hFFFF_F000),
        .slave_2_addr(32'h0000_1000),
        .slave_3_mask(32'hFFFF_FF00),
        .slave_3_addr(32'h0002_0000)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .wbm_adr_i(m_adr), .wbm_dat_i(m_wdat), .wbm_dat_o(m_rdat),
        .wbm_sel_i(m_sel), .wbm_we_i(m_we), .wbm_cyc_i(m_cyc),
        .wbm_stb_i(m_stb), .wbm_ack_o(m_ack), .wbm_err_o(m_err),
        .wbs_0_adr_o(s_adr[0]), .wbs_0_dat_o(s_wdat[0]),
        .wbs_0_dat_i(s_rdat[0]), .wbs_0_sel_o(s_sel[0]),
        .wbs_0_we_o(s_we[0]), .wbs_0_cyc_o(s_cyc[0]),
        .wbs_0_stb_o(s_stb[0]), .wbs_0_ack_i(s_ack[0]),
        .wbs_1_adr_o(s_adr[1]), .wbs_1_dat_o(s_wdat[1]),
        .wbs_1_dat_i(s_rdat[1]), .wbs_1_sel_o(s_sel[1]),
        .wbs_1_we_o(s_we[1]), .wbs_1_cyc_o(s_cyc[1]),
        .wbs_1_stb_o(s_stb[1]), .wbs_1_ack_i(s_ack[1]),
        .wbs_2_adr_o(s_adr[2]), .wbs_2_dat_o(s_wdat[2]),
        .wbs_2_dat_i(s_rdat[2]), .wbs_2_sel_o(s_sel[2]),
        .wbs_2_we_o(s_we[2]), .wbs_2_cyc_o(s_cyc[2]),
        .wbs_2_stb_o(s_stb[2]), .wbs_2_ack_i(s_ack[2]),
        .wbs_3_adr_o(s_adr[3]), .wbs_3_dat_o(s_wdat[3]),
        .wbs_3_dat_i(s_rdat[3]), .wbs_3_sel_o(s_sel[3]),
        .wbs_3_we_o(s_we[3]), .wbs_3_cyc_o(s_cyc[3]),
        .wbs_3_stb_o(s_stb[3]), .wbs_3_ack_i(s_ack[3])
    );

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic        cyc;
        logic        stb;
        logic [3:0]  ack;
        logic [3:0]  e_stb;
        logic [3:0]  e_cyc;
        logic        e_ack;
        logic [31:0] e_dat;
    } vec_t;

    vec_t vt [13];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] adr, input logic cyc,
                         input logic stb);
        @(posedge clk);
        #1;
        m_adr = adr;
        m_cyc = cyc;
        m_stb = stb;
    endtask

    // Counts err pulses over n negedges.
    task automatic watch(input int n, output int errs);
        errs = 0;
        repeat (n) begin
            @(negedge clk);
            if (m_err) errs++;
        end
    endtask

    initial begin
        int n;

        vt[0]  = '{32'h0000_1004, 0, 1, 1, 4'b0000, 4'b0001, 4'b0001, 0, 32'hDEADBEEF};
        vt[1]  = '{32'h0000_1004, 0, 1, 1, 4'b0001, 4'b0001, 4'b0001, 1, 32'hDEADBEEF};
        vt[2]  = '{32'h0000_1004, 0, 1, 1, 4'b0010, 4'b0001, 4'b0001, 0, 32'hDEADBEEF};
        vt[3]  = '{32'h0000_1004, 0, 1, 1, 4'b0100, 4'b0001, 4'b0001, 0, 32'hDEADBEEF};
        vt[4]  = '{32'h0001_0010, 1, 1, 1, 4'b0000, 4'b0010, 4'b0010, 0, 32'h1111_1111};
        vt[5]  = '{32'h0001_0010, 1, 1, 1, 4'b0010, 4'b0010, 4'b0010, 1, 32'h1111_1111};
        vt[6]  = '{32'h0002_0044, 0, 1, 1, 4'b1000, 4'b1000, 4'b1000, 1, 32'h3333_3333};
        vt[7]  = '{32'h0000_2000, 0, 1, 1, 4'b1111, 4'b0000, 4'b0000, 0, 32'h0};
        vt[8]  = '{32'h0000_1004, 0, 0, 1, 4'b0001, 4'b0000, 4'b0000, 0, 32'h0};
        vt[9]  = '{32'h0000_1004, 0, 1, 0, 4'b0001, 4'b0000, 4'b0001, 0, 32'hDEADBEEF};
        vt[10] = '{32'hFFFF_FFFF, 0, 1, 1, 4'b1111, 4'b0000, 4'b0000, 0, 32'h0};
        vt[11] = '{32'h0000_1FFF, 0, 1, 1, 4'b0000, 4'b0001, 4'b0001, 0, 32'hDEADBEEF};
        vt[12] = '{32'h0000_0FFF, 0, 1, 1, 4'b1111, 4'b0000, 4'b0000, 0, 32'h0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_err", 32'(m_err), 32'h0);
        check("rst_ack", 32'(m_ack), 32'h0);
        check("rst_dat", m_rdat, 32'h0);
        check("rst_stb", 32'(s_stb), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Combinational table
        for (int i = 0; i < 13; i++) begin
            @(posedge clk);
            #1;
            m_adr  = vt[i].adr;
            m_we   = vt[i].we;
            m_cyc  = vt[i].cyc;
            m_stb  = vt[i].stb;
            s_ack  = vt[i].ack;
            m_sel  = 2'(i);
            m_wdat = 32'hC0DE_0000 | 32'(i);
            @(negedge clk);
            check($sformatf("v%0d_stb", i), 32'(s_stb), 32'(vt[i].e_stb));
            check($sformatf("v%0d_cyc", i), 32'(s_cyc), 32'(vt[i].e_cyc));
            check($sformatf("v%0d_ack", i), 32'(m_ack), 32'(vt[i].e_ack));
            check($sformatf("v%0d_dat", i), m_rdat, vt[i].e_dat);
            check($sformatf("v%0d_adr3", i), s_adr[3], vt[i].adr);
            check($sformatf("v%0d_wdat1", i), s_wdat[1],
                  32'hC0DE_0000 | 32'(i));
            check($sformatf("v%0d_we", i), 32'(s_we), {28'h0, {4{vt[i].we}}});
            check($sformatf("v%0d_sel2", i), 32'(s_sel[2]), 32'(i % 4));
        end

        // Idle, then reset to a clean state
        drive(32'h0, 0, 0);
        s_ack = '0;
        m_we  = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Slave 0 read, ack one cycle later
        drive(32'h0000_1004, 1, 1);
        @(negedge clk);
        check("rd_wait_ack", 32'(m_ack), 32'h0);
        @(posedge clk);
        #1;
        s_ack[0] = 1'b1;
        @(negedge clk);
        check("rd_ack", 32'(m_ack), 32'h1);
        check("rd_dat", m_rdat, 32'hDEADBEEF);
        check("rd_err", 32'(m_err), 32'h0);
        drive(32'h0, 0, 0);
        s_ack = '0;

        // Unmapped access: err exactly one cycle after strobe
        drive(32'h0000_2000, 1, 1);
        @(negedge clk);
        check("um_err0", 32'(m_err), 32'h0);
        check("um_stb", 32'(s_stb), 32'h0);
        @(negedge clk);
        check("um_err1", 32'(m_err), 32'h1);
        check("um_ack", 32'(m_ack), 32'h0);
        check("um_dat", m_rdat, 32'h0);
        @(negedge clk);
        check("um_err2", 32'(m_err), 32'h0);
        drive(32'h0, 0, 0);

        // Timeout: slave 0 never acks
        drive(32'h0000_1004, 1, 1);
        watch(255, n);
        check("to_early", 32'(n), 32'h0);
        @(negedge clk);
        check("to_err", 32'(m_err), 32'h1);
        @(negedge clk);
        check("to_pulse", 32'(m_err), 32'h0);
        drive(32'h0, 0, 0);

        // Ack arriving with the timeout error suppresses the error
        drive(32'h0000_1004, 1, 1);
        watch(255, n);
        check("sup_early", 32'(n), 32'h0);
        @(posedge clk);
        #1;
        s_ack[0] = 1'b1;
        @(negedge clk);
        check("sup_ack", 32'(m_ack), 32'h1);
        check("sup_err", 32'(m_err), 32'h0);
        drive(32'h0, 0, 0);
        s_ack = '0;

        // Reset mid-timeout restarts the count
        drive(32'h0000_1004, 1, 1);
        watch(100, n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        watch(255, n);
        check("rst_mid_early", 32'(n), 32'h0);
        @(negedge clk);
        check("rst_mid_err", 32'(m_err), 32'h1);
        drive(32'h0, 0, 0);

        // Target change mid-wait restarts the count
        drive(32'h0000_1004, 1, 1);
        watch(100, n);
        drive(32'h0002_0000, 1, 1);
        watch(255, n);
        check("chg_early", 32'(n), 32'h0);
        @(negedge clk);
        check("chg_err", 32'(m_err), 32'h1);
        check("chg_stb", 32'(s_stb), 32'b1000);
        drive(32'h0, 0, 0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
